qdrii_b4_sram_model: RTL and testbench

Behavioural QDR II+ burst-of-4 SRAM with separate read and write data ports, 18-bit burst address and four 9-bit byte-write lanes. It is the external-memory side of the QDR II+ controller simulation: it connects to the controller's K/K#, R#, W#, BW#, SA, D and Q pins and returns echo clocks and read data. The model uses a single clock (K), with data on both K edges.

---
 rtl/qdrii_b4_sram_model.sv | 177 +++++++++++++++++
 tb/tb_qdrii_b4_sram_model.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdrii_b4_sram_model.sv
// Purpose : behavioural QDR II+ burst-of-4 SRAM (36-bit D/Q, 18-bit burst address, 4x9-bit byte writes).
// Latency : read beat 0 on the falling K edge 2.5 cycles after the accept edge; write beats captured at t0+1..t0+2.5.
// Backpressure: none; too-close or colliding commands are dropped. Optional QDR_SRAM_PROTOCOL_CHECK_EN reports them.
module qdrii_b4_sram_model #(
    parameter int DATA_WIDTH = 36,
    parameter int BW_WIDTH   = 4,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                  K,
    input  logic                  sys_rst,
    input  logic                  Kb,
    input  logic                  RPSb,
    input  logic                  WPSb,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  BWS0b,
    input  logic                  BWS1b,
    input  logic                  BWS2b,
    input  logic                  BWS3b,
    input  logic                  DOFF,
    input  logic                  ZQ,
    input  logic                  ODT,
    input  logic                  TCK,
    input  logic                  TMS,
    input  logic                  TDI,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  QVLD,
    output logic                  CQ,
    output logic                  CQb,
    output logic                  TDO
);

    localparam int LANE_W  = DATA_WIDTH / BW_WIDTH;
    localparam int HALF_AW = ADDR_WIDTH + 1;
    localparam int DEPTH   = 1 << HALF_AW;

    // Storage is split by beat parity: even beats (0,2) are written on rising K
    // and read on falling K, odd beats (1,3) the other way round. A read therefore
    // never races a write of the same word on the same edge, and each half has a
    // single writing process.
    logic [DATA_WIDTH-1:0] mem_even [DEPTH];
    logic [DATA_WIDTH-1:0] mem_odd  [DEPTH];

    logic [BW_WIDTH-1:0]   bw_n;
    logic [3:0]            rd_vld;
    logic [ADDR_WIDTH-1:0] rd_addr [4];
    logic [2:0]            wr_vld;
    logic [ADDR_WIDTH-1:0] wr_addr [3];
    logic                  rd_acc;
    logic                  wr_acc;
    logic [HALF_AW-1:0]    wr_even_idx;
    logic [HALF_AW-1:0]    wr_odd_idx;
    logic [DATA_WIDTH-1:0] q_rise;
    logic [DATA_WIDTH-1:0] q_fall;
    logic                  qv_rise;
    logic                  qv_fall;
    logic                  live;
    logic                  unused_pins;

    assign bw_n = {BWS3b, BWS2b, BWS1b, BWS0b};

    // rd_vld[0]/wr_vld[0] mark a command accepted on the previous rising edge,
    // which is exactly the too-close case. A read wins a collision with a write.
    assign rd_acc = DOFF && !RPSb && !rd_vld[0];
    assign wr_acc = DOFF && !WPSb && RPSb && !wr_vld[0];

    // Write beat 0 uses the burst accepted one cycle ago, beat 2 the one two cycles ago.
    assign wr_even_idx = wr_vld[0] ? {wr_addr[0], 1'b0} : {wr_addr[1], 1'b1};
    // Write beat 1 at t0+1.5, beat 3 at t0+2.5.
    assign wr_odd_idx  = wr_vld[1] ? {wr_addr[1], 1'b0} : {wr_addr[2], 1'b1};

    // Rising-edge command pipelines and the odd read beats (1 at t0+3, 3 at t0+4).
    always_ff @(posedge K or negedge sys_rst) begin
        if (!sys_rst) begin
            rd_vld  <= '0;
            wr_vld  <= '0;
            q_rise  <= '0;
            qv_rise <= 1'b0;
            for (int i = 0; i < 4; i++) rd_addr[i] <= '0;
            for (int i = 0; i < 3; i++) wr_addr[i] <= '0;
        end else if (!DOFF) begin
            rd_vld  <= '0;
            wr_vld  <= '0;
            q_rise  <= '0;
            qv_rise <= 1'b0;
        end else begin
            rd_vld     <= {rd_vld[2:0], rd_acc};
            wr_vld     <= {wr_vld[1:0], wr_acc};
            rd_addr[0] <= A;
            wr_addr[0] <= A;
            for (int i = 1; i < 4; i++) rd_addr[i] <= rd_addr[i-1];
            for (int i = 1; i < 3; i++) wr_addr[i] <= wr_addr[i-1];
            if (rd_vld[2]) begin
                q_rise  <= mem_odd[{rd_addr[2], 1'b0}];
                qv_rise <= 1'b1;
            end else if (rd_vld[3]) begin
                q_rise  <= mem_odd[{rd_addr[3], 1'b1}];
                qv_rise <= 1'b1;
            end else begin
                q_rise  <= '0;
                qv_rise <= 1'b0;
            end
        end
    end

    // Falling-edge even read beats (0 at t0+2.5, 2 at t0+3.5).
    always_ff @(negedge K or negedge sys_rst) begin
        if (!sys_rst) begin
            q_fall  <= '0;
            qv_fall <= 1'b0;
        end else if (!DOFF) begin
            q_fall  <= '0;
            qv_fall <= 1'b0;
        end else if (rd_vld[2]) begin
            q_fall  <= mem_even[{rd_addr[2], 1'b0}];
            qv_fall <= 1'b1;
        end else if (rd_vld[3]) begin
            q_fall  <= mem_even[{rd_addr[3], 1'b1}];
            qv_fall <= 1'b1;
        end else begin
            q_fall  <= '0;
            qv_fall <= 1'b0;
        end
    end

    // Even write beats on rising K; masked lanes keep their contents.
    // Reset needs no term here: it clears wr_vld asynchronously.
    always_ff @(posedge K) begin
        if (DOFF && (wr_vld[0] || wr_vld[1])) begin
            for (int i = 0; i < BW_WIDTH; i++) begin
                if (!bw_n[i]) mem_even[wr_even_idx][i*LANE_W +: LANE_W] <= D[i*LANE_W +: LANE_W];
            end
        end
    end

    // Odd write beats on falling K; masked lanes keep their contents.
    always_ff @(negedge K) begin
        if (DOFF && (wr_vld[1] || wr_vld[2])) begin
            for (int i = 0; i < BW_WIDTH; i++) begin
                if (!bw_n[i]) mem_odd[wr_odd_idx][i*LANE_W +: LANE_W] <= D[i*LANE_W +: LANE_W];
            end
        end
    end

    // Each half-cycle shows the register loaded on the edge that opened it, so
    // Q/QVLD change on the K edge itself. Reset and DOFF silence the pins at once.
    assign live = sys_rst && DOFF;
    assign Q    = !live ? '0 : (K ? q_rise : q_fall);
    assign QVLD = live && (K ? qv_rise : qv_fall);
    assign CQ   = live && K;
    assign CQb  = !live || !K;
    assign TDO  = 1'b0;

    assign unused_pins = &{Kb, ZQ, ODT, TCK, TMS, TDI};

`ifdef QDR_SRAM_PROTOCOL_CHECK_EN
    logic burst_active;
    assign burst_active = (|rd_vld) || (|wr_vld);

    // Report dropped commands and clock/DLL abuse while a burst is in flight.
    always @(posedge K) begin
        if (sys_rst && DOFF) begin
            if (!RPSb && rd_vld[0])
                $error("%0t: read to %h ignored, too close to previous read", $time, A);
            if (!WPSb && !RPSb)
                $error("%0t: write to %h ignored, collides with read", $time, A);
            else if (!WPSb && wr_vld[0])
                $error("%0t: write to %h ignored, too close to previous write", $time, A);
        end
        if (sys_rst && burst_active && !DOFF)
            $error("%0t: DOFF low during active burst", $time);
        if (sys_rst && burst_active && (Kb == K))
            $error("%0t: Kb not complementary to K during active burst", $time);
    end
`endif

endmodule

// File: tb/tb_qdrii_b4_sram_model.sv
// Directed bench for the QDR II+ burst-of-4 SRAM model.
// Inputs change 1 time unit after a K edge; outputs are sampled 1 unit after the edge.
// Expected data are hand-computed constants.
module tb_qdrii_b4_sram_model;

    logic        K;
    logic        Kb;
    logic        sys_rst;
    logic        RPSb;
    logic        WPSb;
    logic [17:0] A;
    logic [35:0] D;
    logic [3:0]  bws;
    logic        DOFF;
    logic [35:0] Q;
    logic        QVLD;
    logic        CQ;
    logic        CQb;
    logic        TDO;

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_beats [0:7];

    qdrii_b4_sram_model dut (
        .K(K), .sys_rst(sys_rst), .Kb(Kb), .RPSb(RPSb), .WPSb(WPSb),
        .A(A), .D(D),
        .BWS0b(bws[0]), .BWS1b(bws[1]), .BWS2b(bws[2]), .BWS3b(bws[3]),
        .DOFF(DOFF), .ZQ(1'b0), .ODT(1'b0), .TCK(1'b0), .TMS(1'b0), .TDI(1'b0),
        .Q(Q), .QVLD(QVLD), .CQ(CQ), .CQb(CQb), .TDO(TDO)
    );

    initial K = 1'b0;
    always #5 K = ~K;
    assign Kb = ~K;

    task automatic chk_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns 1 unit after the accepting rising edge R0.
    task automatic issue_read(input logic [17:0] addr);
        @(negedge K);
        #1;
        RPSb = 1'b0;
        A    = addr;
        @(posedge K);
        #1;
        RPSb = 1'b1;
    endtask

    task automatic issue_write(input logic [17:0] addr, input logic [35:0] d0, input logic [35:0] d1,
                               input logic [35:0] d2, input logic [35:0] d3, input logic [3:0] bwb);
        @(negedge K);
        #1;
        WPSb = 1'b0;
        A    = addr;
        @(posedge K);
        #1;
        WPSb = 1'b1;
        D    = d0;
        bws  = bwb;
        @(posedge K);
        #1;
        D = d1;
        @(negedge K);
        #1;
        D = d2;
        @(posedge K);
        #1;
        D = d3;
        @(negedge K);
        #1;
        D   = '0;
        bws = 4'hF;
    endtask

    // Called 1 unit after R0: QVLD low at R2, n beats from F2 on alternating edges, then idle.
    task automatic check_burst(input string tag, input int n);
        @(posedge K);
        @(posedge K);
        #1;
        chk_eq({tag, "_pre_vld"}, {35'd0, QVLD}, 36'd0);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) @(negedge K);
            else            @(posedge K);
            #1;
            chk_eq($sformatf("%s_q%0d", tag, i), Q, exp_beats[i]);
            chk_eq($sformatf("%s_vld%0d", tag, i), {35'd0, QVLD}, 36'd1);
        end
        if (n % 2 == 0) @(negedge K);
        else            @(posedge K);
        #1;
        chk_eq({tag, "_post_vld"}, {35'd0, QVLD}, 36'd0);
        chk_eq({tag, "_post_q"}, Q, 36'd0);
    endtask

    task automatic set_masked_exp();
        exp_beats[0] = 36'hFFFFD11FF;
        exp_beats[1] = 36'hFFFFE23FF;
        exp_beats[2] = 36'hFFFFF33FF;
        exp_beats[3] = 36'hFFFFC45FF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        sys_rst = 1'b0;
        RPSb    = 1'b1;
        WPSb    = 1'b1;
        A       = '0;
        D       = '0;
        bws     = 4'hF;
        DOFF    = 1'b1;

        // Reset state, sampled while K is high.
        #7;
        chk_eq("rst_q", Q, 36'd0);
        chk_eq("rst_qvld", {35'd0, QVLD}, 36'd0);
        chk_eq("rst_cq", {35'd0, CQ}, 36'd0);
        chk_eq("rst_cqb", {35'd0, CQb}, 36'd1);
        chk_eq("rst_tdo", {35'd0, TDO}, 36'd0);
        @(negedge K);
        #1;
        sys_rst = 1'b1;
        @(posedge K);
        #1;
        chk_eq("cq_hi", {35'd0, CQ}, 36'd1);
        chk_eq("cqb_hi", {35'd0, CQb}, 36'd0);
        @(negedge K);
        #1;
        chk_eq("cq_lo", {35'd0, CQ}, 36'd0);
        chk_eq("cqb_lo", {35'd0, CQb}, 36'd1);

        // Full write then read back in beat order.
        issue_write(18'h00010, 36'h111111111, 36'h222222222, 36'h333333333, 36'h444444444, 4'h0);
        exp_beats[0] = 36'h111111111;
        exp_beats[1] = 36'h222222222;
        exp_beats[2] = 36'h333333333;
        exp_beats[3] = 36'h444444444;
        issue_read(18'h00010);
        check_burst("wr_rd", 4);

        // All-ones with lane 1 masked: bits [17:9] keep the old data.
        issue_write(18'h00010, 36'hFFFFFFFFF, 36'hFFFFFFFFF, 36'hFFFFFFFFF, 36'hFFFFFFFFF, 4'b0010);
        set_masked_exp();
        issue_read(18'h00010);
        check_burst("mask", 4);

        // Second buffer for the back-to-back test.
        issue_write(18'h00020, 36'hA00000001, 36'hA00000002, 36'hA00000003, 36'hA00000004, 4'h0);

        // Reads on consecutive rising edges: the second (to 0x20) is dropped.
        set_masked_exp();
        @(negedge K);
        #1;
        RPSb = 1'b0;
        A    = 18'h00010;
        @(posedge K);
        #1;
        A = 18'h00020;
        fork
            begin
                @(posedge K);
                #1;
                RPSb = 1'b1;
            end
            check_burst("close", 4);
        join

        // Reads two cycles apart: 8 contiguous beats.
        set_masked_exp();
        exp_beats[4] = 36'hA00000001;
        exp_beats[5] = 36'hA00000002;
        exp_beats[6] = 36'hA00000003;
        exp_beats[7] = 36'hA00000004;
        issue_read(18'h00010);
        fork
            begin
                @(posedge K);
                #1;
                RPSb = 1'b0;
                A    = 18'h00020;
                @(posedge K);
                #1;
                RPSb = 1'b1;
            end
            check_burst("b2b", 8);
        join

        // Read/write collision: the read returns old data, the write is dropped.
        exp_beats[0] = 36'hA00000001;
        exp_beats[1] = 36'hA00000002;
        exp_beats[2] = 36'hA00000003;
        exp_beats[3] = 36'hA00000004;
        @(negedge K);
        #1;
        RPSb = 1'b0;
        WPSb = 1'b0;
        A    = 18'h00020;
        D    = 36'h555555555;
        bws  = 4'h0;
        @(posedge K);
        #1;
        RPSb = 1'b1;
        WPSb = 1'b1;
        check_burst("coll", 4);
        D   = '0;
        bws = 4'hF;
        issue_read(18'h00020);
        check_burst("coll_after", 4);

        // DOFF low silences the echo clock while K is high.
        @(posedge K);
        #1;
        DOFF = 1'b0;
        #1;
        chk_eq("doff_cq", {35'd0, CQ}, 36'd0);
        chk_eq("doff_cqb", {35'd0, CQb}, 36'd1);
        @(negedge K);
        #1;
        DOFF = 1'b1;
        @(posedge K);
        #1;
        chk_eq("doff_cq_back", {35'd0, CQ}, 36'd1);

        // Reset mid-read: outputs drop immediately, burst aborted, memory intact.
        set_masked_exp();
        issue_read(18'h00010);
        @(posedge K);
        @(posedge K);
        @(negedge K);
        #1;
        chk_eq("mid_q0", Q, exp_beats[0]);
        @(posedge K);
        #2;
        sys_rst = 1'b0;
        #1;
        chk_eq("mid_rst_q", Q, 36'd0);
        chk_eq("mid_rst_qvld", {35'd0, QVLD}, 36'd0);
        chk_eq("mid_rst_cq", {35'd0, CQ}, 36'd0);
        chk_eq("mid_rst_cqb", {35'd0, CQb}, 36'd1);
        @(negedge K);
        #1;
        sys_rst = 1'b1;
        @(posedge K);
        #1;
        chk_eq("abort_qvld", {35'd0, QVLD}, 36'd0);
        chk_eq("abort_q", Q, 36'd0);
        @(posedge K);
        issue_read(18'h00010);
        check_burst("post_rst", 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
